// File: rtl/puf_s04_apb_sequencer_pkg.sv
// rtl/puf_s04_apb_sequencer_pkg.sv - shared APB widths, PUF register offsets, response codes and state encodings
// Holds the constants that the sequencer top and its single-transfer APB engine share.
package puf_s04_apb_sequencer_pkg;

  localparam int APB_ADDR_WIDTH   = 32;
  localparam int APB_DATA_WIDTH   = 32;
  localparam int APB_STROBE_WIDTH = APB_DATA_WIDTH / 8;

  localparam logic [APB_ADDR_WIDTH-1:0] PUF_CTRL_ADDR = 'h00;
  localparam logic [APB_ADDR_WIDTH-1:0] PUF_STAT_ADDR = 'h04;
  localparam logic [APB_ADDR_WIDTH-1:0] PUF_CHAL_ADDR = 'h08;
  localparam logic [APB_ADDR_WIDTH-1:0] PUF_RESP_ADDR = 'h0C;

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_SLVERR  = 2'd1;
  localparam logic [1:0] RSP_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_CHAL  = 3'd1,
    ST_WR_START = 3'd2,
    ST_POLL     = 3'd3,
    ST_RD_RESP  = 3'd4,
    ST_RESP     = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    XFER_IDLE   = 2'd0,
    XFER_SETUP  = 2'd1,
    XFER_ACCESS = 2'd2
  } xfer_phase_t;

  // Poll counter must stick at all-ones rather than wrap back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/puf_apb_master_xfer.sv
// rtl/puf_apb_master_xfer.sv - single APB transfer engine (SETUP, ACCESS with wait states, error capture)
// A start accepted on the completing ACCESS cycle chains straight into the next SETUP with psel held high.
module puf_apb_master_xfer
  import puf_s04_apb_sequencer_pkg::*;
(
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic                        start,
  input  logic [APB_ADDR_WIDTH-1:0]   addr,
  input  logic                        write,
  input  logic [APB_DATA_WIDTH-1:0]   wdata,
  output logic                        done,
  output logic                        err,
  output logic [APB_DATA_WIDTH-1:0]   rdata,
  output logic [APB_ADDR_WIDTH-1:0]   paddr,
  output logic [APB_DATA_WIDTH-1:0]   pwdata,
  output logic [2:0]                  pprot,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [APB_STROBE_WIDTH-1:0] pstrb,
  input  logic                        pready,
  input  logic                        pslverr,
  input  logic [APB_DATA_WIDTH-1:0]   prdata
);

  xfer_phase_t phase_q;
  xfer_phase_t phase_d;
  logic        load;

  assign done  = (phase_q == XFER_ACCESS) && pready;
  assign err   = done && pslverr;
  assign rdata = prdata;
  assign load  = start && ((phase_q == XFER_IDLE) || done);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      phase_q <= XFER_IDLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      XFER_IDLE:   if (start) phase_d = XFER_SETUP;
      XFER_SETUP:  phase_d = XFER_ACCESS;
      XFER_ACCESS: if (pready) phase_d = start ? XFER_SETUP : XFER_IDLE;
      default:     phase_d = XFER_IDLE;
    endcase
  end

  // Address and data are only reloaded at a transfer boundary, so they stay put through wait states.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
      pstrb  <= '0;
    end else if (load) begin
      paddr  <= addr;
      pwdata <= wdata;
      pwrite <= write;
      pstrb  <= {APB_STROBE_WIDTH{write}};
    end
  end

  always_comb begin
    psel    = (phase_q != XFER_IDLE);
    penable = (phase_q == XFER_ACCESS);
    pprot   = 3'b000;
  end

endmodule

// File: rtl/puf_s04_apb_sequencer.sv
// rtl/puf_s04_apb_sequencer.sv - PUF challenge/response sequencer driving an APB master
// Writes the challenge, kicks the PUF, polls for done, reads the response, and hands back a coded result.
module puf_s04_apb_sequencer
  import puf_s04_apb_sequencer_pkg::*;
#(
  parameter logic [APB_ADDR_WIDTH-1:0] CTRL_ADDR = PUF_CTRL_ADDR,
  parameter logic [APB_ADDR_WIDTH-1:0] STAT_ADDR = PUF_STAT_ADDR,
  parameter logic [APB_ADDR_WIDTH-1:0] CHAL_ADDR = PUF_CHAL_ADDR,
  parameter logic [APB_ADDR_WIDTH-1:0] RESP_ADDR = PUF_RESP_ADDR,
  parameter int unsigned               POLL_MAX  = 255
) (
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic                        req_valid,
  input  logic [APB_DATA_WIDTH-1:0]   req_challenge,
  output logic                        req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [APB_DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]                  rsp_code,
  output logic [APB_ADDR_WIDTH-1:0]   paddr,
  output logic [APB_DATA_WIDTH-1:0]   pwdata,
  output logic [2:0]                  pprot,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [APB_STROBE_WIDTH-1:0] pstrb,
  input  logic                        pready,
  input  logic                        pslverr,
  input  logic [APB_DATA_WIDTH-1:0]   prdata
);

  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

  seq_state_t                state_q;
  seq_state_t                state_d;
  logic                      rst_done_q;
  logic [7:0]                poll_cnt_q;
  logic [APB_DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]                rsp_code_q;

  logic                      xfer_start;
  logic [APB_ADDR_WIDTH-1:0] xfer_addr;
  logic                      xfer_write;
  logic [APB_DATA_WIDTH-1:0] xfer_wdata;
  logic                      x_done;
  logic                      x_err;
  logic [APB_DATA_WIDTH-1:0] x_rdata;

  logic accept;
  logic ok_done;
  logic stat_done;
  logic poll_last;

  // rst_done_q keeps req_ready low while reset is held even though the FSM already sits in IDLE.
  assign accept    = req_valid && (state_q == ST_IDLE) && rst_done_q;
  assign ok_done   = x_done && !x_err;
  assign stat_done = x_rdata[0];
  assign poll_last = (poll_cnt_q == POLL_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= ST_IDLE;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (accept) state_d = ST_WR_CHAL;
      ST_WR_CHAL:  if (x_done) state_d = x_err ? ST_RESP : ST_WR_START;
      ST_WR_START: if (x_done) state_d = x_err ? ST_RESP : ST_POLL;
      ST_POLL: begin
        if (x_done) begin
          if (x_err)          state_d = ST_RESP;
          else if (stat_done) state_d = ST_RD_RESP;
          else if (poll_last) state_d = ST_RESP;
        end
      end
      ST_RD_RESP:  if (x_done) state_d = ST_RESP;
      ST_RESP:     if (rsp_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // The next transfer is requested in the completing cycle so its SETUP follows without a gap.
  always_comb begin
    req_ready  = (state_q == ST_IDLE) && rst_done_q;
    rsp_valid  = (state_q == ST_RESP);
    xfer_start = 1'b0;
    xfer_addr  = '0;
    xfer_write = 1'b0;
    xfer_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          xfer_start = 1'b1;
          xfer_addr  = CHAL_ADDR;
          xfer_write = 1'b1;
          xfer_wdata = req_challenge;
        end
      end
      ST_WR_CHAL: begin
        if (ok_done) begin
          xfer_start = 1'b1;
          xfer_addr  = CTRL_ADDR;
          xfer_write = 1'b1;
          xfer_wdata = APB_DATA_WIDTH'(1);
        end
      end
      ST_WR_START: begin
        if (ok_done) begin
          xfer_start = 1'b1;
          xfer_addr  = STAT_ADDR;
        end
      end
      ST_POLL: begin
        if (ok_done && stat_done) begin
          xfer_start = 1'b1;
          xfer_addr  = RESP_ADDR;
        end else if (ok_done && !poll_last) begin
          xfer_start = 1'b1;
          xfer_addr  = STAT_ADDR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      poll_cnt_q <= '0;
    end else if (accept) begin
      poll_cnt_q <= '0;
    end else if ((state_q == ST_POLL) && ok_done && !stat_done) begin
      poll_cnt_q <= sat_inc8(poll_cnt_q);
    end
  end

  // Result registers only move on a completing transfer, so they hold steady throughout RESP.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_data_q <= '0;
      rsp_code_q <= RSP_OK;
    end else if (x_done) begin
      if (x_err) begin
        rsp_data_q <= '0;
        rsp_code_q <= RSP_SLVERR;
      end else if (state_q == ST_RD_RESP) begin
        rsp_data_q <= x_rdata;
        rsp_code_q <= RSP_OK;
      end else if ((state_q == ST_POLL) && !stat_done && poll_last) begin
        rsp_data_q <= '0;
        rsp_code_q <= RSP_TIMEOUT;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_code = rsp_code_q;

  puf_apb_master_xfer u_xfer (
    .pclk    (pclk),
    .presetn (presetn),
    .start   (xfer_start),
    .addr    (xfer_addr),
    .write   (xfer_write),
    .wdata   (xfer_wdata),
    .done    (x_done),
    .err     (x_err),
    .rdata   (x_rdata),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pprot   (pprot),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pstrb   (pstrb),
    .pready  (pready),
    .pslverr (pslverr),
    .prdata  (prdata)
  );

endmodule

// File: tb/tb_puf_s04_apb_sequencer.sv
// tb/tb_puf_s04_apb_sequencer.sv - directed bench for the PUF APB sequencer
// A behavioural APB slave with configurable wait states, done flag and error address sits behind the DUT.
module tb_puf_s04_apb_sequencer;
  import puf_s04_apb_sequencer_pkg::*;

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_STAT = 32'h04;
  localparam logic [31:0] A_CHAL = 32'h08;
  localparam logic [31:0] A_RESP = 32'h0C;

  logic        pclk;
  logic        presetn;
  logic        req_valid;
  logic [31:0] req_challenge;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_code;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int total = 0;
  int bad   = 0;

  int          ws = 0;
  bit          stat_done_cfg = 1'b1;
  logic [31:0] resp_val = 32'h0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  int          wait_cnt = 0;
  bit          stab_err = 1'b0;
  bit          prot_err = 1'b0;
  logic [31:0] setup_addr = 32'h0;
  logic [31:0] setup_wdata = 32'h0;
  logic        setup_write = 1'b0;
  logic [31:0] log_addr[$];
  logic        log_write[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_strb[$];

  puf_s04_apb_sequencer #(.POLL_MAX(4)) dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .req_valid     (req_valid),
    .req_challenge (req_challenge),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_code      (rsp_code),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .pprot         (pprot),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .pstrb         (pstrb),
    .pready        (pready),
    .pslverr       (pslverr),
    .prdata        (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Slave decides pready for the coming edge on the falling edge and logs each completing transfer.
  always @(negedge pclk) begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h0;
    if (psel && pprot !== 3'b000) prot_err = 1'b1;
    if (psel && !penable) begin
      setup_addr  = paddr;
      setup_wdata = pwdata;
      setup_write = pwrite;
      wait_cnt    = 0;
    end else if (psel && penable) begin
      if (paddr !== setup_addr || pwdata !== setup_wdata || pwrite !== setup_write) stab_err = 1'b1;
      if (wait_cnt >= ws) begin
        pready  = 1'b1;
        pslverr = err_en && (paddr == err_addr);
        if (!pwrite) prdata = (paddr == A_STAT) ? {31'b0, stat_done_cfg} :
                              (paddr == A_RESP) ? resp_val : 32'hDEAD_BEEF;
        log_addr.push_back(paddr);
        log_write.push_back(pwrite);
        log_wdata.push_back(pwdata);
        log_strb.push_back(pstrb);
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic clear_log;
    log_addr.delete();
    log_write.delete();
    log_wdata.delete();
    log_strb.delete();
  endtask

  task automatic do_request(input logic [31:0] chal, output int cyc);
    @(negedge pclk);
    req_valid     = 1'b1;
    req_challenge = chal;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge pclk);
    @(posedge pclk);
    #1;
    req_valid = 1'b0;
    cyc = -1;
    for (int n = 0; n < 400; n++) begin
      if (rsp_valid) begin
        cyc = n + 1;
        break;
      end
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic take_rsp;
    @(negedge pclk);
    rsp_ready = 1'b1;
    @(posedge pclk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    total++;
    if ({psel, penable, pwrite} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=000", {psel, penable, pwrite});
    end
    total++;
    if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pprot !== 3'h0) begin
      bad++;
      $display("FAIL reset_bus got addr=%h wdata=%h strb=%h prot=%h want all zero", paddr, pwdata, pstrb, pprot);
    end
    total++;
    if ({req_ready, rsp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_hs got=%b want=00", {req_ready, rsp_valid});
    end
    total++;
    if (rsp_data !== 32'h0 || rsp_code !== 2'd0) begin
      bad++;
      $display("FAIL reset_rsp got data=%h code=%0d want 0/0", rsp_data, rsp_code);
    end
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk);
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_zero_wait;
    int          cyc;
    logic [31:0] ea[4];
    logic        ew[4];
    ea[0] = A_CHAL; ea[1] = A_CTRL; ea[2] = A_STAT; ea[3] = A_RESP;
    ew[0] = 1'b1;   ew[1] = 1'b1;   ew[2] = 1'b0;   ew[3] = 1'b0;
    ws = 0; stat_done_cfg = 1'b1; resp_val = 32'h1234_5678; prot_err = 1'b0;
    clear_log();
    do_request(32'hA5A5_0001, cyc);
    total++;
    if (cyc != 9) begin
      bad++;
      $display("FAIL zw_latency got=%0d want=9", cyc);
    end
    total++;
    if (rsp_data !== 32'h1234_5678 || rsp_code !== 2'd0) begin
      bad++;
      $display("FAIL zw_rsp got data=%h code=%0d want 12345678/0", rsp_data, rsp_code);
    end
    total++;
    if (log_addr.size() != 4) begin
      bad++;
      $display("FAIL zw_count got=%0d want=4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (log_addr[i] !== ea[i] || log_write[i] !== ew[i] || log_strb[i] !== (ew[i] ? 4'hF : 4'h0)) begin
          bad++;
          $display("FAIL zw_xfer%0d got addr=%h w=%b strb=%h want addr=%h w=%b", i, log_addr[i], log_write[i], log_strb[i], ea[i], ew[i]);
        end
      end
      total++;
      if (log_wdata[0] !== 32'hA5A5_0001 || log_wdata[1] !== 32'h1) begin
        bad++;
        $display("FAIL zw_wdata got %h %h want a5a50001 00000001", log_wdata[0], log_wdata[1]);
      end
    end
    total++;
    if (prot_err) begin
      bad++;
      $display("FAIL zw_pprot got nonzero want=000");
    end
    take_rsp();
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL zw_after_take got valid/ready=%b want=01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_wait_states;
    int cyc;
    ws = 3; stat_done_cfg = 1'b1; resp_val = 32'h8765_4321; stab_err = 1'b0;
    clear_log();
    do_request(32'h5A5A_F00F, cyc);
    total++;
    if (cyc != 21) begin
      bad++;
      $display("FAIL ws_latency got=%0d want=21", cyc);
    end
    total++;
    if (stab_err) begin
      bad++;
      $display("FAIL ws_stable got=unstable want=stable");
    end
    total++;
    if (rsp_data !== 32'h8765_4321 || rsp_code !== 2'd0 || log_addr.size() != 4) begin
      bad++;
      $display("FAIL ws_rsp got data=%h code=%0d n=%0d want 87654321/0/4", rsp_data, rsp_code, log_addr.size());
    end
    take_rsp();
    ws = 0;
  endtask

  task automatic test_timeout;
    int cyc;
    int nstat;
    ws = 0; stat_done_cfg = 1'b0;
    clear_log();
    do_request(32'h0000_00FF, cyc);
    nstat = 0;
    foreach (log_addr[i]) if (log_addr[i] == A_STAT) nstat++;
    total++;
    if (nstat != 4 || log_addr.size() != 6) begin
      bad++;
      $display("FAIL to_reads got stat=%0d all=%0d want 4/6", nstat, log_addr.size());
    end
    total++;
    if (rsp_code !== 2'd2 || rsp_data !== 32'h0) begin
      bad++;
      $display("FAIL to_rsp got code=%0d data=%h want 2/0", rsp_code, rsp_data);
    end
    total++;
    if (cyc != 13) begin
      bad++;
      $display("FAIL to_latency got=%0d want=13", cyc);
    end
    take_rsp();
    stat_done_cfg = 1'b1;
  endtask

  task automatic test_slverr;
    int cyc;
    int nstat;
    ws = 0; err_en = 1'b1; err_addr = A_CTRL; resp_val = 32'h1111_2222;
    clear_log();
    do_request(32'hC0DE_0003, cyc);
    nstat = 0;
    foreach (log_addr[i]) if (log_addr[i] == A_STAT) nstat++;
    total++;
    if (nstat != 0 || log_addr.size() != 2) begin
      bad++;
      $display("FAIL se_reads got stat=%0d all=%0d want 0/2", nstat, log_addr.size());
    end
    total++;
    if (rsp_code !== 2'd1 || rsp_data !== 32'h0 || cyc != 5) begin
      bad++;
      $display("FAIL se_rsp got code=%0d data=%h cyc=%0d want 1/0/5", rsp_code, rsp_data, cyc);
    end
    take_rsp();
    err_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc;
    int viol;
    ws = 0; stat_done_cfg = 1'b1; resp_val = 32'hCAFE_0042;
    clear_log();
    do_request(32'h0BAD_F00D, cyc);
    total++;
    if (cyc != 9 || rsp_data !== 32'hCAFE_0042) begin
      bad++;
      $display("FAIL b2b_first got cyc=%0d data=%h want 9/cafe0042", cyc, rsp_data);
    end
    @(negedge pclk);
    req_valid = 1'b1;
    req_challenge = 32'h1357_9BDF;
    rsp_ready = 1'b0;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge pclk);
      #1;
      if (!rsp_valid || rsp_data !== 32'hCAFE_0042 || rsp_code !== 2'd0 || req_ready) viol++;
    end
    total++;
    if (viol != 0 || log_addr.size() != 4) begin
      bad++;
      $display("FAIL b2b_hold got viol=%0d n=%0d want 0/4", viol, log_addr.size());
    end
    @(negedge pclk);
    rsp_ready = 1'b1;
    @(posedge pclk);
    #1;
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, req_ready, psel} !== 3'b010) begin
      bad++;
      $display("FAIL b2b_handshake got valid/ready/psel=%b want=010", {rsp_valid, req_ready, psel});
    end
    @(posedge pclk);
    #1;
    req_valid = 1'b0;
    total++;
    if ({psel, penable, req_ready} !== 3'b100 || paddr !== A_CHAL || pwdata !== 32'h1357_9BDF) begin
      bad++;
      $display("FAIL b2b_accept got sel/en/rdy=%b addr=%h wdata=%h want 100/08/13579bdf", {psel, penable, req_ready}, paddr, pwdata);
    end
    cyc = -1;
    for (int n = 0; n < 100; n++) begin
      if (rsp_valid) begin
        cyc = n;
        break;
      end
      @(posedge pclk);
      #1;
    end
    total++;
    if (cyc < 0) begin
      bad++;
      $display("FAIL b2b_second got=no response want=response");
    end
    take_rsp();
  endtask

  task automatic test_reset_mid;
    bit found;
    int nsel;
    ws = 2; stat_done_cfg = 1'b0;
    @(negedge pclk);
    req_valid = 1'b1;
    req_challenge = 32'h7777_0007;
    @(posedge pclk);
    #1;
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (psel && penable && paddr == A_STAT) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rm_poll got=no poll access want=poll access");
    end
    #2;
    presetn = 1'b0;
    #1;
    total++;
    if ({psel, penable, req_ready, rsp_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL rm_async got sel/en/rdy/vld=%b want=0000", {psel, penable, req_ready, rsp_valid});
    end
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    clear_log();
    @(posedge pclk);
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rm_ready got=%b want=1", req_ready);
    end
    nsel = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk);
      #1;
      if (psel) nsel++;
    end
    total++;
    if (nsel != 0 || log_addr.size() != 0) begin
      bad++;
      $display("FAIL rm_no_replay got sel_cycles=%0d xfers=%0d want 0/0", nsel, log_addr.size());
    end
    ws = 0; stat_done_cfg = 1'b1;
  endtask

  initial begin
    presetn       = 1'b0;
    req_valid     = 1'b0;
    req_challenge = 32'h0;
    rsp_ready     = 1'b0;
    pready        = 1'b0;
    pslverr       = 1'b0;
    prdata        = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_slverr();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
